inst_mem_ctrl: RTL and testbench
================================

// Module: inst_mem_ctrl
// PURPOSE
//  Instruction-side responder for the fetch stage: accepts one-cycle fetch requests (instEn/instAddr),
//  answers same-cycle from a direct-mapped I-cache on hit, else reads 4 bytes over the byte-wide
//  RAM port, assembles a little-endian word, returns it with a one-cycle memInstOutEn pulse, fills cache.
//  Sits between fetch and the memory arbiter; the instruction image is read-only at run time.
// PARAMETERS
//  INDEX_W   7   cache index bits (2**INDEX_W one-word lines); index = instAddr[INDEX_W+1:2]
//  RAM_AW    17  RAM byte-address width driven on ramAddr
// PORTS
//  clk          in   1       system clock; single clock domain
//  rst          in   1       synchronous, active-high reset
//  instEn       in   1       fetch request strobe, one-cycle pulse
//  instAddr     in   32      word-aligned fetch address, valid while instEn=1
//  hit          out  1       combinational: cache hit for instAddr this cycle
//  cacheInst    out  32      cached word, valid when hit=1
//  memInstOutEn out  1       one-cycle pulse: memInst valid (miss completion)
//  memInst      out  32      assembled instruction word
//  ramReq       out  1       byte read request to arbiter
//  ramAddr      out  RAM_AW  byte address of current request
//  ramGrant     in   1       arbiter accepts ramReq this cycle
//  ramData      in   8       read byte, valid exactly 1 cycle after a granted request
// BEHAVIOUR
//  Reset: hit=0, memInstOutEn=0, memInst=0, ramReq=0, ramAddr=0, all valid bits cleared, state IDLE.
//  Hit path (IDLE only): hit = instEn & valid[idx] & tag[idx]==instAddr[31:INDEX_W+2]; cacheInst=data[idx];
//   zero latency, no state change, no RAM traffic. hit forced 0 outside IDLE.
//  Miss: instEn & ~hit in IDLE latches addr, issue/recv counters <=0, -> FETCH.
//  FETCH: ramReq=1 while issued<4, ramAddr=addr[RAM_AW-1:0]+issued; issued++ only on ramGrant.
//   Byte granted at cycle t captured at t+1 into word[8*k+7:8*k], k = byte offset (little-endian).
//   Grant low stalls issue only; an in-flight byte is still captured.
//  On 4th byte captured -> DONE (registered): memInstOutEn=1 one cycle, memInst=word; cache line
//   written (valid,tag,data) same edge; -> IDLE. memInst holds value until next completion.
//  Min miss latency: request at T, grants T+1..T+4, memInstOutEn high at T+6.
//  instEn while not IDLE: ignored (fetch never does this; no response generated).
//  instAddr[1:0]!=0: low bits ignored (treated as aligned).
//  Reset mid-miss: request abandoned, no memInstOutEn, cache fill not performed.
//  Same-index different-tag miss overwrites line (direct-mapped replacement).
// CONFIGURATION
//  ICACHE_EN defined: cache arrays + hit path as above.
//  ICACHE_EN undefined: no arrays; hit=0, cacheInst=0 constant; every request takes miss path.
// STRUCTURE
//  defines.v: Enable/Disable, addrFree/dataFree, InstAddrBus/InstBus, PCnext, state encodings
//   (Idle/Fetch/Done), byte-count width.
//  Sub-module icache_array (valid/tag/data, combinational read, sync write); top keeps FSM/assembly.
// TESTING
//  Cold miss: ram bytes 0x13,0x05,0x10,0x00 @0x0, instEn@0x0, grant=1 -> memInstOutEn@T+6, memInst=0x00100513.
//  Re-fetch 0x0 -> hit=1 same cycle, cacheInst=0x00100513, ramReq stays 0 (ICACHE_EN).
//  Grant low 3 cycles after 2nd byte -> completion delayed 3 cycles, word still correct.
//  Conflict: fetch 0x0 then 0x200 (INDEX_W=7) -> both miss; re-fetch 0x0 misses again.
//  rst during FETCH -> no memInstOutEn, outputs 0, next fetch of same addr misses.
//  ICACHE_EN off: repeated fetch 0x4 -> hit never 1, each takes >=6 cycles via RAM.

Source files
------------

// File: rtl/inst_mem_ctrl_pkg.sv
// inst_mem_ctrl_pkg: shared FSM states and fetch counter sizing for the instruction memory controller.
package inst_mem_ctrl_pkg;
   typedef enum logic [1:0] {IDLE, FETCH, DONE} state_e;
   localparam int CNT_W      = 3;
   localparam int WORD_BYTES = 4;
endpackage

// File: rtl/inst_mem_ctrl_icache_array.sv
// inst_mem_ctrl_icache_array: direct-mapped one-word-per-line storage, combinational read, synchronous fill.
module inst_mem_ctrl_icache_array
   import inst_mem_ctrl_pkg::*;
#(
   parameter int INDEX_W = 7,
   parameter int TAG_W   = 23
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [INDEX_W-1:0] rd_idx_i,
   output logic               rd_valid_o,
   output logic [TAG_W-1:0]   rd_tag_o,
   output logic [31:0]        rd_data_o,
   input  logic               wr_en_i,
   input  logic [INDEX_W-1:0] wr_idx_i,
   input  logic [TAG_W-1:0]   wr_tag_i,
   input  logic [31:0]        wr_data_i
);
   localparam int LINES = 2**INDEX_W;
   logic [LINES-1:0] valid_q;
   logic [TAG_W-1:0] tag_q  [LINES];
   logic [31:0]      data_q [LINES];
   assign rd_valid_o = valid_q[rd_idx_i];
   assign rd_tag_o   = tag_q[rd_idx_i];
   assign rd_data_o  = data_q[rd_idx_i];
   always_ff @(posedge clk) begin
      if (rst) valid_q <= '0;
      else if (wr_en_i) valid_q[wr_idx_i] <= 1'b1;
   end
   // tag/data need no reset: valid gates every read
   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         tag_q[wr_idx_i]  <= wr_tag_i;
         data_q[wr_idx_i] <= wr_data_i;
      end
   end
endmodule

// File: rtl/inst_mem_ctrl.sv
// inst_mem_ctrl: fetch responder; cache hit same cycle, else 4 byte RAM reads assembled little-endian.
// Optional I-cache enabled by defining ICACHE_EN; without it every fetch goes to RAM.
module inst_mem_ctrl
   import inst_mem_ctrl_pkg::*;
#(
   parameter int INDEX_W = 7,
   parameter int RAM_AW  = 17
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              instEn,
   input  logic [31:0]       instAddr,
   output logic              hit,
   output logic [31:0]       cacheInst,
   output logic              memInstOutEn,
   output logic [31:0]       memInst,
   output logic              ramReq,
   output logic [RAM_AW-1:0] ramAddr,
   input  logic              ramGrant,
   input  logic [7:0]        ramData
);
   localparam int TAG_W = 32 - INDEX_W - 2;
   state_e           state_q, state_d;
   logic [31:0]      addr_q, addr_d, word_q, word_d, mem_inst_q, mem_inst_d;
   logic [CNT_W-1:0] issued_q, issued_d;
   logic [1:0]       recv_q, recv_d, pend_k_q, pend_k_d;
   logic             pend_q, pend_d, fill;
   logic             unused_bits;
   assign unused_bits  = ^{addr_q[31:RAM_AW], addr_q[1:0]};
   assign memInstOutEn = state_q == DONE;
   assign memInst      = mem_inst_q;
`ifdef ICACHE_EN
   logic             rd_valid;
   logic [TAG_W-1:0] rd_tag;
   inst_mem_ctrl_icache_array #(.INDEX_W(INDEX_W), .TAG_W(TAG_W)) u_array (
      .clk        (clk),
      .rst        (rst),
      .rd_idx_i   (instAddr[INDEX_W+1:2]),
      .rd_valid_o (rd_valid),
      .rd_tag_o   (rd_tag),
      .rd_data_o  (cacheInst),
      .wr_en_i    (fill),
      .wr_idx_i   (addr_q[INDEX_W+1:2]),
      .wr_tag_i   (addr_q[31:INDEX_W+2]),
      .wr_data_i  (word_d)
   );
   assign hit = state_q == IDLE && instEn && rd_valid && rd_tag == instAddr[31:INDEX_W+2];
`else
   assign hit       = 1'b0;
   assign cacheInst = '0;
`endif
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      issued_d   = issued_q;
      recv_d     = recv_q;
      pend_d     = 1'b0;
      pend_k_d   = pend_k_q;
      word_d     = word_q;
      mem_inst_d = mem_inst_q;
      fill       = 1'b0;
      ramReq     = state_q == FETCH && issued_q < CNT_W'(WORD_BYTES);
      ramAddr    = ramReq ? {addr_q[RAM_AW-1:2], 2'b00} + RAM_AW'(issued_q) : '0;
      case (state_q)
         IDLE: if (instEn && !hit) begin
            addr_d   = instAddr;
            issued_d = '0;
            recv_d   = '0;
            state_d  = FETCH;
         end
         FETCH: begin
            if (ramReq && ramGrant) begin
               issued_d = issued_q + 1'b1;
               pend_d   = 1'b1;
               pend_k_d = issued_q[1:0];
            end
            // byte granted last cycle arrives now, regardless of this cycle's grant
            if (pend_q) begin
               word_d[8*pend_k_q +: 8] = ramData;
               recv_d = recv_q + 1'b1;
               if (recv_q == 2'd3) begin
                  fill       = 1'b1;
                  mem_inst_d = word_d;
                  state_d    = DONE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         issued_q   <= '0;
         recv_q     <= '0;
         pend_q     <= 1'b0;
         pend_k_q   <= '0;
         word_q     <= '0;
         mem_inst_q <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         issued_q   <= issued_d;
         recv_q     <= recv_d;
         pend_q     <= pend_d;
         pend_k_q   <= pend_k_d;
         word_q     <= word_d;
         mem_inst_q <= mem_inst_d;
      end
   end
endmodule

// File: tb/tb_inst_mem_ctrl.sv
// tb_inst_mem_ctrl: directed fetch sequence against a byte-RAM model with an expected-word scoreboard.
module tb_inst_mem_ctrl;
`ifdef ICACHE_EN
   localparam bit CACHE = 1'b1;
`else
   localparam bit CACHE = 1'b0;
`endif
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        instEn = 1'b0;
   logic [31:0] instAddr = '0;
   logic        hit, memInstOutEn, ramReq;
   logic [31:0] cacheInst, memInst;
   logic [16:0] ramAddr;
   logic        ramGrant = 1'b1;
   logic [7:0]  ramData;
   logic [7:0]  mem [1024];
   logic        rd_pend = 1'b0;
   logic [16:0] rd_addr = '0;
   logic [31:0] sb [$];
   int          passed = 0;
   int          total = 0;

   inst_mem_ctrl dut (
      .clk(clk), .rst(rst), .instEn(instEn), .instAddr(instAddr), .hit(hit),
      .cacheInst(cacheInst), .memInstOutEn(memInstOutEn), .memInst(memInst),
      .ramReq(ramReq), .ramAddr(ramAddr), .ramGrant(ramGrant), .ramData(ramData)
   );

   always #5 clk = ~clk;

   // RAM answers one cycle after a granted request
   always @(posedge clk) begin
      rd_pend <= ramReq && ramGrant;
      rd_addr <= ramAddr;
   end
   assign ramData = rd_pend ? mem[rd_addr[9:0]] : 8'hEE;

   function automatic logic [31:0] model_word(input logic [31:0] a);
      logic [9:0] b;
      b = {a[9:2], 2'b00};
      return {mem[b + 10'd3], mem[b + 10'd2], mem[b + 10'd1], mem[b]};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issues one fetch at the current cycle; stall holds grant low for that many
   // requesting cycles once two bytes have been granted.
   task automatic fetch(input logic [31:0] a, input bit warm, input int stall);
      bit exp_hit;
      int n, g, left;
      logic [31:0] exp_w;
      exp_hit = CACHE && warm;
      instEn = 1'b1;
      instAddr = a;
      #1;
      check($sformatf("hit@%h", a), 32'(hit), 32'(exp_hit));
      check($sformatf("ramReq_idle@%h", a), 32'(ramReq), 32'd0);
      if (exp_hit) check($sformatf("cacheInst@%h", a), cacheInst, model_word(a));
      else sb.push_back(model_word(a));
      step();
      instEn = 1'b0;
      instAddr = $urandom;
      if (!exp_hit) begin
         n = 1;
         g = 0;
         left = stall;
         check($sformatf("ramAddr0@%h", a), {15'd0, ramAddr}, {a[31:2], 2'b00} & 32'h1FFFF);
         while (!memInstOutEn && n < 40) begin
            ramGrant = !(ramReq && g == 2 && left > 0);
            if (ramReq && !ramGrant) left--;
            if (ramReq && ramGrant) g++;
            #1;
            step();
            ramGrant = 1'b1;
            n++;
         end
         check($sformatf("latency@%h", a), n, 6 + stall);
         check($sformatf("outEn@%h", a), 32'(memInstOutEn), 32'd1);
         exp_w = sb.size() > 0 ? sb.pop_front() : 32'hDEADBEEF;
         check($sformatf("memInst@%h", a), memInst, exp_w);
         step();
         check($sformatf("pulse_end@%h", a), 32'(memInstOutEn), 32'd0);
         check($sformatf("memInst_hold@%h", a), memInst, exp_w);
      end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 8'(i * 37 + 11);
      mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'h10; mem[3] = 8'h00;
      repeat (2) step();
      check("rst_hit", 32'(hit), 32'd0);
      check("rst_outEn", 32'(memInstOutEn), 32'd0);
      check("rst_memInst", memInst, 32'd0);
      check("rst_ramReq", 32'(ramReq), 32'd0);
      check("rst_ramAddr", {15'd0, ramAddr}, 32'd0);
      rst = 1'b0;
      step();
      fetch(32'h0, 1'b0, 0);
      check("cold_word", memInst, 32'h00100513);
      fetch(32'h0, 1'b1, 0);
      fetch(32'h4, 1'b0, 0);
      fetch(32'h4, 1'b1, 0);
      fetch(32'h8, 1'b0, 3);
      fetch(32'h8, 1'b1, 0);
      fetch(32'h200, 1'b0, 0);
      fetch(32'h0, 1'b0, 0);
      fetch(32'h200, 1'b0, 0);
      fetch(32'h6, 1'b1, 0);
      // reset in the middle of a miss
      instEn = 1'b1;
      instAddr = 32'h40;
      step();
      instEn = 1'b0;
      repeat (2) step();
      rst = 1'b1;
      step();
      check("midrst_outEn", 32'(memInstOutEn), 32'd0);
      check("midrst_memInst", memInst, 32'd0);
      check("midrst_ramReq", 32'(ramReq), 32'd0);
      check("midrst_ramAddr", {15'd0, ramAddr}, 32'd0);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         check("midrst_quiet", 32'(memInstOutEn), 32'd0);
      end
      fetch(32'h40, 1'b0, 0);
      fetch(32'h40, 1'b1, 0);
      fetch(32'h0, 1'b0, 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
